// File: rtl/noise_lfsr_tracker_pkg.sv
// Shared types and defaults for the PSG noise-channel LFSR tracker.
package noise_trk_pkg;

  // Tracker FSM states
  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } trk_state_t;

  // Generator LFSR defaults
  localparam int DEF_LFSR_BITS = 15;
  localparam int DEF_TAP0      = 0;
  localparam int DEF_TAP1      = 1;

  // Mismatch counter geometry
  localparam int ERR_CNT_W     = 8;
  localparam int ERR_CNT_MAX   = 255;

endpackage

// File: rtl/noise_lfsr_tracker_if.sv
// Sample stream from the noise generator plus tracker status outputs.
interface noise_lfsr_tracker_if;
  import noise_trk_pkg::*;

  logic                 bit_valid;
  logic                 bit_in;
  logic                 is_white_noise;
  logic                 clear_err;
  logic                 locked;
  logic                 predict;
  logic                 mismatch;
  logic                 lost;
  logic [ERR_CNT_W-1:0] err_count;

  // Sample source / status observer side
  modport master (
    output bit_valid, bit_in, is_white_noise, clear_err,
    input  locked, predict, mismatch, lost, err_count
  );

  // Tracker side
  modport slave (
    input  bit_valid, bit_in, is_white_noise, clear_err,
    output locked, predict, mismatch, lost, err_count
  );

endinterface

// File: rtl/noise_lfsr_tracker_predictor.sv
// Sample window and per-sample mode history; predicts the next noise output bit
// from the generator recurrence o[n] = o[n-L+TAP0] ^ (white ? o[n-L+TAP1] : 0).
module noise_predictor #(
  parameter int LFSR_BITS = 15,
  parameter int TAP0      = 0,
  parameter int TAP1      = 1
) (
  input  logic clk,
  input  logic reset_lfsr,
  input  logic shift_en,
  input  logic bit_in,
  input  logic mode_in,
  output logic predict
);

  // window[0] / mode_hist[0] hold the oldest sample
  logic [LFSR_BITS-1:0] window_q, window_d;
  logic [LFSR_BITS-1:0] mode_hist_q, mode_hist_d;

  // Shift the new sample and its feedback mode in at the top on every valid sample
  always_comb begin
    window_d    = window_q;
    mode_hist_d = mode_hist_q;
    if (shift_en) begin
      window_d    = {bit_in,  window_q[LFSR_BITS-1:1]};
      mode_hist_d = {mode_in, mode_hist_q[LFSR_BITS-1:1]};
    end
  end

  // Window and mode history registers, cleared with the generator LFSR
  always_ff @(posedge clk or posedge reset_lfsr) begin
    if (reset_lfsr) begin
      window_q    <= '0;
      mode_hist_q <= '0;
    end else begin
      window_q    <= window_d;
      mode_hist_q <= mode_hist_d;
    end
  end

  // The feedback bit that becomes o[n] was computed on the step that produced
  // sample n-L+1, so that sample's captured mode (index 1) selects the tap set.
  assign predict = window_q[TAP0] ^ (mode_hist_q[1] & window_q[TAP1]);

endmodule

// File: rtl/noise_lfsr_tracker.sv
// Receive-side lock monitor for the PSG noise channel: acquires LFSR_BITS samples,
// then tracks the generator by predicting each bit and flagging divergence.
// Optional build macro NOISE_TRK_ERRCNT_EN enables the saturating err_count and
// its clear_err input; without it err_count reads 0 and clear_err is ignored.
module noise_lfsr_tracker
  import noise_trk_pkg::*;
#(
  parameter int LFSR_BITS   = DEF_LFSR_BITS,
  parameter int LFSR_TAP0   = DEF_TAP0,
  parameter int LFSR_TAP1   = DEF_TAP1,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 reset_lfsr,
  noise_lfsr_tracker_if.slave  bus
);

  localparam int ACQ_W  = $clog2(LFSR_BITS);
  localparam int MISS_W = 4;

  trk_state_t        state_q, state_d;
  logic [ACQ_W-1:0]  acq_cnt_q, acq_cnt_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [MISS_W-1:0] miss_inc;
  logic              mismatch_q, mismatch_d;
  logic              lost_q, lost_d;
  logic              miss;
  logic              predict;

  noise_predictor #(
    .LFSR_BITS (LFSR_BITS),
    .TAP0      (LFSR_TAP0),
    .TAP1      (LFSR_TAP1)
  ) u_predictor (
    .clk        (clk),
    .reset_lfsr (reset_lfsr),
    .shift_en   (bus.bit_valid),
    .bit_in     (bus.bit_in),
    .mode_in    (bus.is_white_noise),
    .predict    (predict)
  );

  assign miss_inc = miss_cnt_q + 1'b1;

  // Next-state logic: acquisition counting, prediction compare and loss detection
  always_comb begin
    state_d    = state_q;
    acq_cnt_d  = acq_cnt_q;
    miss_cnt_d = miss_cnt_q;
    mismatch_d = 1'b0;
    lost_d     = 1'b0;
    miss       = 1'b0;
    case (state_q)
      ACQUIRE: begin
        if (bus.bit_valid) begin
          if (acq_cnt_q == ACQ_W'(LFSR_BITS - 1)) begin
            state_d   = TRACK;
            acq_cnt_d = '0;
          end else begin
            acq_cnt_d = acq_cnt_q + 1'b1;
          end
        end
      end
      TRACK: begin
        if (bus.bit_valid) begin
          miss       = bus.bit_in ^ predict;
          mismatch_d = miss;
          if (miss) begin
            if (miss_inc == MISS_W'(LOSS_THRESH)) begin
              // Window is kept but must be refilled before it is trusted again
              lost_d     = 1'b1;
              state_d    = ACQUIRE;
              acq_cnt_d  = '0;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end
      end
      default: state_d = ACQUIRE;
    endcase
  end

  // FSM, counters and pulse output registers
  always_ff @(posedge clk or posedge reset_lfsr) begin
    if (reset_lfsr) begin
      state_q    <= ACQUIRE;
      acq_cnt_q  <= '0;
      miss_cnt_q <= '0;
      mismatch_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acq_cnt_q  <= acq_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      mismatch_q <= mismatch_d;
      lost_q     <= lost_d;
    end
  end

`ifdef NOISE_TRK_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_W'(ERR_CNT_MAX)) ? v : v + 1'b1;
  endfunction

  // Error counter: clear wins over a same-cycle increment
  always_comb begin
    err_count_d = err_count_q;
    if (bus.clear_err) begin
      err_count_d = '0;
    end else if (miss) begin
      err_count_d = sat_inc(err_count_q);
    end
  end

  // Error counter register
  always_ff @(posedge clk or posedge reset_lfsr) begin
    if (reset_lfsr) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.err_count = err_count_q;
`else
  logic unused_clear_err;
  assign unused_clear_err = bus.clear_err;
  assign bus.err_count    = '0;
`endif

  assign bus.locked   = (state_q == TRACK);
  assign bus.predict  = predict;
  assign bus.mismatch = mismatch_q;
  assign bus.lost     = lost_q;

endmodule

// File: tb/tb_noise_lfsr_tracker.sv
// Directed bench for noise_lfsr_tracker: periodic/white acquisition, tracking,
// single and repeated errors, loss/relock, mode switch, async reset, clear_err.
module tb_noise_lfsr_tracker;

`ifdef NOISE_TRK_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_lfsr;
  int   checks = 0;
  int   errors = 0;
  logic [14:0] gen;
  logic b;

  always #5 clk = ~clk;

  noise_lfsr_tracker_if bus ();

  noise_lfsr_tracker #(
    .LFSR_BITS   (15),
    .LFSR_TAP0   (0),
    .LFSR_TAP1   (1),
    .LOSS_THRESH (4)
  ) dut (
    .clk        (clk),
    .reset_lfsr (reset_lfsr),
    .bus        (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference noise generator: shift right, feedback into bit 14, output bit 0
  task automatic gen_next(input logic white, output logic ob);
    logic fb;
    fb  = white ? (gen[0] ^ gen[1]) : gen[0];
    gen = {fb, gen[14:1]};
    ob  = gen[0];
  endtask

  // One valid sample; returns just after the capturing edge (back-to-back capable)
  task automatic send(input logic bi, input logic white, input logic clr = 1'b0);
    bus.bit_valid      = 1'b1;
    bus.bit_in         = bi;
    bus.is_white_noise = white;
    bus.clear_err      = clr;
    @(negedge clk);
    bus.bit_valid      = 1'b0;
    bus.clear_err      = 1'b0;
  endtask

  task automatic idle();
    bus.bit_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_lfsr = 1'b1;
    @(negedge clk);
    reset_lfsr = 1'b0;
  endtask

  initial begin
    bus.bit_valid      = 1'b0;
    bus.bit_in         = 1'b0;
    bus.is_white_noise = 1'b0;
    bus.clear_err      = 1'b0;
    reset_lfsr         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_locked",   bus.locked,    0);
    chk("rst_predict",  bus.predict,   0);
    chk("rst_mismatch", bus.mismatch,  0);
    chk("rst_lost",     bus.lost,      0);
    chk("rst_err",      bus.err_count, 0);
    reset_lfsr = 1'b0;

    // 1: periodic, pattern of 14 zeros then a one
    for (int i = 0; i < 15; i++) begin
      if (i == 14) chk("t1_locked_pre", bus.locked, 0);
      send((i % 15) == 14, 1'b0);
      chk("t1_acq_mismatch", bus.mismatch, 0);
    end
    chk("t1_locked", bus.locked, 1);
    for (int i = 15; i < 45; i++) begin
      chk("t1_predict", bus.predict, (i % 15) == 14);
      send((i % 15) == 14, 1'b0);
      chk("t1_mismatch", bus.mismatch, 0);
    end

    // 2: white, reference LFSR seeded 0x4000
    do_reset();
    gen = 15'h4000;
    for (int i = 0; i < 60; i++) begin
      gen_next(1'b1, b);
      if (i == 14) chk("t2_locked_pre", bus.locked, 0);
      if (i >= 15) chk("t2_predict", bus.predict, b);
      send(b, 1'b1);
      chk("t2_mismatch", bus.mismatch, 0);
    end
    chk("t2_locked", bus.locked, 1);

    // 3: one inverted sample while locked
    gen_next(1'b1, b);
    send(~b, 1'b1);
    chk("t3_mismatch", bus.mismatch, 1);
    chk("t3_err",      bus.err_count, ERR_EN ? 1 : 0);
    chk("t3_locked",   bus.locked, 1);
    chk("t3_lost",     bus.lost, 0);
    idle();
    chk("t3_mismatch_idle", bus.mismatch, 0);
    for (int i = 0; i < 5; i++) begin
      gen_next(1'b1, b);
      send(b, 1'b1);
      chk("t3_mismatch_after", bus.mismatch, 0);
    end

    // 4: four consecutive wrong samples force re-acquisition
    for (int k = 0; k < 4; k++) begin
      gen_next(1'b1, b);
      send(~b, 1'b1);
      chk("t4_mismatch", bus.mismatch, 1);
      chk("t4_lost",     bus.lost, k == 3);
      chk("t4_locked",   bus.locked, k < 3);
    end
    chk("t4_err", bus.err_count, ERR_EN ? 5 : 0);
    idle();
    chk("t4_lost_idle", bus.lost, 0);
    for (int i = 0; i < 15; i++) begin
      gen_next(1'b1, b);
      if (i == 14) chk("t4_relock_pre", bus.locked, 0);
      send(b, 1'b1);
      chk("t4_acq_mismatch", bus.mismatch, 0);
    end
    chk("t4_relocked", bus.locked, 1);
    for (int i = 0; i < 5; i++) begin
      gen_next(1'b1, b);
      chk("t4_predict", bus.predict, b);
      send(b, 1'b1);
      chk("t4_mismatch_after", bus.mismatch, 0);
    end

    // 5: white -> periodic switch mid-stream, no relock needed
    for (int i = 0; i < 30; i++) begin
      gen_next(1'b0, b);
      chk("t5_predict", bus.predict, b);
      send(b, 1'b0);
      chk("t5_mismatch", bus.mismatch, 0);
      chk("t5_locked",   bus.locked, 1);
    end

    // 6: seven isolated errors, then async reset with no clock edge
    do_reset();
    gen = 15'h4000;
    for (int i = 0; i < 15; i++) begin
      gen_next(1'b0, b);
      send(b, 1'b0);
    end
    chk("t6_locked", bus.locked, 1);
    for (int k = 0; k < 13; k++) begin
      gen_next(1'b0, b);
      send((k % 2 == 0) ? ~b : b, 1'b0);
      chk("t6_mismatch", bus.mismatch, k % 2 == 0);
    end
    chk("t6_err7",        bus.err_count, ERR_EN ? 7 : 0);
    chk("t6_locked_errs", bus.locked, 1);
    #2;
    reset_lfsr = 1'b1;
    #1;
    chk("t6_async_locked",   bus.locked, 0);
    chk("t6_async_err",      bus.err_count, 0);
    chk("t6_async_mismatch", bus.mismatch, 0);
    @(negedge clk);
    reset_lfsr = 1'b0;

    // clear_err in the same cycle as a mismatch
    for (int i = 0; i < 15; i++) begin
      gen_next(1'b0, b);
      send(b, 1'b0);
    end
    chk("t6_relocked", bus.locked, 1);
    gen_next(1'b0, b);
    send(~b, 1'b0);
    chk("t6_err1", bus.err_count, ERR_EN ? 1 : 0);
    gen_next(1'b0, b);
    send(b, 1'b0);
    chk("t6_match", bus.mismatch, 0);
    gen_next(1'b0, b);
    send(~b, 1'b0, 1'b1);
    chk("t6_clr_mismatch", bus.mismatch, 1);
    chk("t6_clr_err",      bus.err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
